text_console: RTL and testbench
===============================

# text_console

Character-cell text buffer feeding the glyph renderer. It holds a 160×90 grid of 16-bit cells (`{ascii, fg, bg}`) and serves cell reads addressed by the timing source's block coordinates, one cycle late. It also outputs the pixel coordinates delayed to match. A byte-stream write port prints characters at a cursor, handling control codes, line wrap and hardware scrolling; scrolling uses a ring-buffer row offset plus line clearing.

## Interface
- `COLS`, 160, cells per row (1280/8)
- `ROWS`, 90, rows (720/8)
- `DEFAULT_ATTR`, 8'h F0, attribute `{fg, bg}` loaded at reset
- `i_pclk`  in  1  pixel clock; all logic on rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_bx`, `i_by`  in  9 each  cell coordinates from timing source
- `i_px`, `i_py`  in  12 each  pixel coordinates from timing source
- `o_char`  out  16  cell for (`i_bx`, `i_by`) of previous cycle
- `o_x`, `o_y`  out  12 each  `i_px`/`i_py` delayed 1 cycle, aligned with `o_char`
- `i_valid`  in  1  write byte valid
- `i_data`  in  8  byte (printable or control)
- `i_attr`  in  8  `{fg, bg}` sampled with each accepted printable byte
- `o_ready`  out  1  byte accepted on `i_valid && o_ready`
- `o_cur_col`  out  8  cursor column, logical
- `o_cur_row`  out  7  cursor row, logical (0 = top of screen)

## Operation
- Storage: COLS*ROWS cells, 14-bit address `phys_row*COLS + col`. `phys_row = row + top`, minus ROWS if the sum is ≥ ROWS. `top` is the ring offset, range 0..ROWS-1.
- Read path: if `i_bx` ≥ COLS or `i_by` ≥ ROWS, the next-cycle `o_char` = 16'h0000. Otherwise `o_char` = stored cell. RAM read is registered and read-first: a same-address write in the same cycle returns old data.
- `attr_q` register: reset `DEFAULT_ATTR`; loaded from `i_attr` on each printable byte. The fill cell is `{8'h20, attr_q}`.
- States:
  - IDLE: `o_ready` = 1.
  - CLEAR_LINE: `o_ready` = 0. Writes fill to COLS cells of one physical row, col 0..COLS-1.
  - CLEAR_ALL: `o_ready` = 0. Writes fill to all COLS*ROWS addresses, 0..14399 ascending.
  - Either clear state returns to IDLE after its last write.
- Accepted byte handling in IDLE:
  - 0x20–0x7E, 0x80–0xFF: write `{i_data, i_attr}` at the cursor. If `col` < COLS-1, `col`++. Otherwise `col` = 0 and do a newline.
  - 0x0A LF: `col` = 0 and newline.
  - 0x0D CR: `col` = 0.
  - 0x08 BS: if `col` > 0, `col`--. No write.
  - 0x0C FF: cursor = (0,0), `top` = 0, enter CLEAR_ALL.
  - Any other byte: accepted, no effect.
- Newline: if `row` < ROWS-1, `row`++. Otherwise `top` = (`top`+1) mod ROWS, `row` stays ROWS-1, and enter CLEAR_LINE on the new bottom physical row (the old `top`).
- Reset: state = CLEAR_ALL, so memory is initialised to `{8'h20, DEFAULT_ATTR}`. Reset mid-clear restarts the full clear from address 0.

## Timing
- Reset values: `o_char` 0, `o_x`/`o_y` 0, `o_ready` 0, cursor (0,0), `top` 0, `attr_q` `DEFAULT_ATTR`.
- Read latency: exactly 1 cycle for `o_char`, `o_x` and `o_y`. The read path is unaffected by write activity.
- A printable byte accepted at edge N is visible to a read issued at edge N+1 or later.
- Scroll: after the accepting edge, `o_ready` is low for exactly COLS (160) cycles. `top` and the cursor update on the accepting edge.
- CLEAR_ALL (reset or FF): `o_ready` is low for exactly 14400 cycles.
- Consecutive printable bytes sustain 1 byte/cycle.
- Wrap on the last column of the last row triggers a scroll, identical to LF.

## Structure
- Package `console_pkg`:
  - `cell_t` packed struct `{ascii[7:0], fg[3:0], bg[3:0]}`
  - control-code constants `CC_BS`, `CC_LF`, `CC_FF`, `CC_CR`
  - state enum `{IDLE, CLEAR_LINE, CLEAR_ALL}`
  - constants `COLS_DEF`, `ROWS_DEF`
- Sub-module `char_ram`: simple dual-port RAM, one write port, one registered read-first port, depth COLS*ROWS, 16 bits wide. Inferable as block RAM.

## Test plan
- Reset: `o_ready` low 14400 cycles, then high. Read of (5,7) → `o_char` 16'h20F0 one cycle later.
- Write 0x41 with `i_attr` 8'h1F → read (0,0) returns 16'h411F. `o_cur_col` = 1. `o_x`/`o_y` equal previous-cycle `i_px`/`i_py`.
- 161 printable bytes from (0,0) → byte 161 lands at (0,1), cursor (1,1). BS at col 0 → cursor unchanged, no write.
- Fill rows 0..89, cursor on row 89, send LF → `o_ready` low 160 cycles. Logical row 0 now reads former row 1. Row 89 reads `{8'h20, attr_q}`.
- FF mid-screen → `o_ready` low 14400 cycles, every cell is fill, cursor (0,0). Assert `i_rst` at clear cycle 5000 → clear restarts, 14400 cycles.
- Read (160,0) and (0,90) → 16'h0000. Write and read the same address in the same cycle → old value returned.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and constants for the text console: cell layout, control
// codes, write-side FSM states and default grid geometry.
package console_pkg;

  localparam int COLS_DEF = 160;  // 1280 / 8
  localparam int ROWS_DEF = 90;   // 720 / 8

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef struct packed {
    logic [7:0] ascii;
    logic [3:0] fg;
    logic [3:0] bg;
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_LINE,
    CLEAR_ALL
  } state_e;

  // Bytes that land in the buffer: 0x20..0x7E and 0x80..0xFF (DEL excluded).
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte-stream write port of the text console: valid/ready handshake with
// the character byte and the attribute sampled alongside it.
interface text_console_if;
  logic       valid;
  logic [7:0] data;
  logic [7:0] attr;
  logic       ready;

  modport master (output valid, output data, output attr, input ready);
  modport slave  (input valid, input data, input attr, output ready);
endinterface

// File: rtl/text_console_char_ram.sv
// Simple dual-port cell RAM: one write port, one registered read-first read
// port. Plain array with no reset so it maps onto block RAM.
module char_ram #(
  parameter int DEPTH = 14400,
  parameter int AW    = 14,
  parameter int DW    = 16
) (
  input  logic          i_pclk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write and registered read in one process; the read samples the old
  // contents on a same-address collision (read-first).
  // NOTE: the memory array has no reset branch -- a reset loop over 14400
  // entries would stop it mapping to block RAM; the clear FSM initialises it.
  always_ff @(posedge i_pclk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/text_console.sv
// Character-cell text buffer: serves cell reads for the glyph renderer one
// cycle late, and prints a byte stream at a cursor with control codes, line
// wrap and ring-buffer hardware scrolling.
module text_console
  import console_pkg::*;
#(
  parameter int         COLS         = COLS_DEF,
  parameter int         ROWS         = ROWS_DEF,
  parameter logic [7:0] DEFAULT_ATTR = 8'hF0
) (
  input  logic          i_pclk,
  input  logic          i_rst,
  input  logic [8:0]    i_bx,
  input  logic [8:0]    i_by,
  input  logic [11:0]   i_px,
  input  logic [11:0]   i_py,
  output logic [15:0]   o_char,
  output logic [11:0]   o_x,
  output logic [11:0]   o_y,
  text_console_if.slave wr,
  output logic [7:0]    o_cur_col,
  output logic [6:0]    o_cur_row
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [8:0]    COLS_B    = 9'(COLS);
  localparam logic [8:0]    ROWS_B    = 9'(ROWS);
  localparam logic [7:0]    ROWS_S    = 8'(ROWS);
  localparam logic [7:0]    LAST_COL  = 8'(COLS - 1);
  localparam logic [6:0]    LAST_ROW  = 7'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LINE_LAST = AW'(COLS - 1);

  // Logical row -> physical row through the ring offset.
  function automatic logic [6:0] ring_row(input logic [6:0] row, input logic [6:0] top);
    logic [7:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= ROWS_S) begin
      return 7'(sum - ROWS_S);
    end
    return sum[6:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [6:0] prow, input logic [7:0] col);
    return AW'(int'(prow) * COLS + int'(col));
  endfunction

  // Write-side state
  state_e        state_q;
  logic [7:0]    col_q;
  logic [6:0]    row_q;
  logic [6:0]    top_q;
  logic [7:0]    attr_q;
  logic [AW-1:0] clr_addr_q;
  logic [AW-1:0] clr_cnt_q;
  logic          ready_q;

  // Read-side state
  logic          rd_ok_q;
  logic [11:0]   x_q;
  logic [11:0]   y_q;

  // RAM ports
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  cell_t         ram_wcell;
  logic [AW-1:0] ram_raddr;
  logic [15:0]   ram_rdata;

  logic          rd_in_range;
  logic          accept;
  logic          printable;
  logic          do_nl;
  logic [6:0]    next_top;

  // Read address: out-of-range coordinates are masked and park the RAM on 0.
  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path through the block can leave it holding a value (no latches).
  always_comb begin
    rd_in_range = (i_bx < COLS_B) && (i_by < ROWS_B);
    ram_raddr   = '0;
    if (rd_in_range) begin
      ram_raddr = cell_addr(ring_row(i_by[6:0], top_q), i_bx[7:0]);
    end
  end

  // Handshake decode and newline decision for the byte accepted this cycle.
  always_comb begin
    accept    = wr.valid && ready_q;
    printable = is_printable(wr.data);
    do_nl     = 1'b0;
    if (accept && (state_q == IDLE)) begin
      do_nl = (printable && (col_q == LAST_COL)) || (wr.data == CC_LF);
    end
    next_top = (top_q == LAST_ROW) ? 7'd0 : top_q + 7'd1;
  end

  // RAM write port: cursor writes in IDLE, fill writes while clearing. The
  // write lands on the accepting edge so the next read already sees it.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wcell = '0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          if (accept && printable) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(ring_row(row_q, top_q), col_q);
            ram_wcell = {wr.data, wr.attr};
          end
        end
        CLEAR_LINE, CLEAR_ALL: begin
          ram_we    = 1'b1;
          ram_waddr = clr_addr_q;
          ram_wcell = {8'h20, attr_q};
        end
        default: ;
      endcase
    end
  end

  // Write FSM: cursor movement, scrolling and the two clear sequences.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state_q    <= CLEAR_ALL;
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      attr_q     <= DEFAULT_ATTR;
      clr_addr_q <= '0;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              attr_q <= wr.attr;
              col_q  <= (col_q == LAST_COL) ? 8'd0 : col_q + 8'd1;
            end else begin
              case (wr.data)
                CC_LF, CC_CR: col_q <= '0;
                CC_BS: begin
                  if (col_q != 8'd0) begin
                    col_q <= col_q - 8'd1;
                  end
                end
                CC_FF: begin
                  col_q      <= '0;
                  row_q      <= '0;
                  top_q      <= '0;
                  clr_addr_q <= '0;
                  state_q    <= CLEAR_ALL;
                  ready_q    <= 1'b0;
                end
                default: ;
              endcase
            end
            if (do_nl) begin
              if (row_q != LAST_ROW) begin
                row_q <= row_q + 7'd1;
              end else begin
                // Scroll: the old top physical row becomes the new bottom.
                top_q      <= next_top;
                clr_addr_q <= cell_addr(top_q, 8'd0);
                clr_cnt_q  <= '0;
                state_q    <= CLEAR_LINE;
                ready_q    <= 1'b0;
              end
            end
          end
        end
        CLEAR_LINE: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          clr_cnt_q  <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LINE_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        CLEAR_ALL: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Read-side pipeline: range flag and pixel coordinates aligned with RAM data.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      rd_ok_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      rd_ok_q <= rd_in_range;
      x_q     <= i_px;
      y_q     <= i_py;
    end
  end

  char_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (16)
  ) u_ram (
    .i_pclk  (i_pclk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wcell),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign o_char    = rd_ok_q ? ram_rdata : 16'h0000;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign wr.ready  = ready_q;
  assign o_cur_col = col_q;
  assign o_cur_row = row_q[6:0];

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a logical-screen model supplies expected
// cells, reads are queued as expectations and popped when the DUT answers.
module tb_text_console;
  import console_pkg::*;

  localparam int COLS = 160;
  localparam int ROWS = 90;

  logic        i_pclk = 1'b0;
  logic        i_rst  = 1'b1;
  logic [8:0]  i_bx   = '0;
  logic [8:0]  i_by   = '0;
  logic [11:0] i_px   = '0;
  logic [11:0] i_py   = '0;
  logic [15:0] o_char;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic [7:0]  o_cur_col;
  logic [6:0]  o_cur_row;

  text_console_if bus ();

  text_console dut (
    .i_pclk    (i_pclk),
    .i_rst     (i_rst),
    .i_bx      (i_bx),
    .i_by      (i_by),
    .i_px      (i_px),
    .i_py      (i_py),
    .o_char    (o_char),
    .o_x       (o_x),
    .o_y       (o_y),
    .wr        (bus),
    .o_cur_col (o_cur_col),
    .o_cur_row (o_cur_row)
  );

  always #5 i_pclk = ~i_pclk;

  int cyc = 0;
  always @(posedge i_pclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] ch;
    logic [11:0] x;
    logic [11:0] y;
    string       tag;
  } rd_t;
  rd_t q[$];

  // Logical screen model (row 0 = top of screen)
  logic [15:0] scr [ROWS][COLS];
  int          cr;
  int          cc;
  logic [7:0]  m_attr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_fill_all(input logic [7:0] a);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = {8'h20, a};
  endtask

  task automatic m_newline();
    if (cr < ROWS - 1) begin
      cr++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++)
        scr[ROWS-1][c] = {8'h20, m_attr};
    end
  endtask

  task automatic m_byte(input logic [7:0] d, input logic [7:0] a);
    if (d >= 8'h20 && d != 8'h7F) begin
      scr[cr][cc] = {d, a};
      m_attr = a;
      if (cc < COLS - 1) cc++;
      else begin cc = 0; m_newline(); end
    end else if (d == 8'h0A) begin
      cc = 0; m_newline();
    end else if (d == 8'h0D) begin
      cc = 0;
    end else if (d == 8'h08) begin
      if (cc > 0) cc--;
    end else if (d == 8'h0C) begin
      cc = 0; cr = 0; m_fill_all(m_attr);
    end
  endtask

  task automatic m_reset();
    cc = 0; cr = 0; m_attr = 8'hF0; m_fill_all(8'hF0);
  endtask

  // Called at a negedge: drives one byte and returns at the negedge after
  // the accepting edge.
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int w = 0;
    bus.valid = 1'b1; bus.data = d; bus.attr = a;
    while (bus.ready !== 1'b1 && w < 20000) begin w++; @(negedge i_pclk); end
    if (w >= 20000) check("send_timeout", 32'(w), 32'd0);
    @(negedge i_pclk);
    bus.valid = 1'b0;
    m_byte(d, a);
  endtask

  task automatic count_busy(input int exp, input string tag);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 20000) begin n++; @(negedge i_pclk); end
    check(tag, 32'(n), 32'(exp));
  endtask

  task automatic compare_head();
    rd_t e;
    e = q.pop_front();
    check({e.tag, "_char"}, 32'(o_char), 32'(e.ch));
    check({e.tag, "_x"}, 32'(o_x), 32'(e.x));
    check({e.tag, "_y"}, 32'(o_y), 32'(e.y));
  endtask

  // Pipelined read: compare the answer to the previous request, issue a new one.
  task automatic issue(input int bx, input int by, input string tag);
    rd_t e;
    if (q.size() > 0) compare_head();
    i_bx = 9'(bx); i_by = 9'(by);
    i_px = 12'(bx * 8 + 3); i_py = 12'(by * 8 + 5);
    if (bx < COLS && by < ROWS) e.ch = scr[by][bx];
    else e.ch = 16'h0000;
    e.x = i_px; e.y = i_py; e.tag = tag;
    q.push_back(e);
    @(negedge i_pclk);
  endtask

  task automatic flush();
    if (q.size() > 0) compare_head();
  endtask

  task automatic rd(input int bx, input int by, input string tag);
    issue(bx, by, tag);
    flush();
  endtask

  logic [15:0] old_cell;
  int t0;

  initial begin
    bus.valid = 1'b0; bus.data = '0; bus.attr = '0;
    i_px = 12'h123; i_py = 12'h321;
    m_reset();

    // Reset state
    repeat (3) @(negedge i_pclk);
    check("rst_char", 32'(o_char), 32'h0);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_col", 32'(o_cur_col), 32'h0);
    check("rst_row", 32'(o_cur_row), 32'h0);
    check("rst_x", 32'(o_x), 32'h0);
    check("rst_y", 32'(o_y), 32'h0);
    i_rst = 1'b0;
    count_busy(14400, "rst_busy");
    rd(5, 7, "rd57");

    // First printable byte, visible on the very next read
    send(8'h41, 8'h1F);
    rd(0, 0, "rd_A");
    check("A_col", 32'(o_cur_col), 32'd1);

    // 161 consecutive printables from (0,0): wrap to row 1, 1 byte/cycle
    send(CC_CR, 8'h00);
    t0 = cyc;
    for (int i = 0; i < 161; i++) send(8'(8'h61 + i % 26), 8'h2E);
    check("thru_cycles", 32'(cyc - t0), 32'd161);
    check("wrap_col", 32'(o_cur_col), 32'd1);
    check("wrap_row", 32'(o_cur_row), 32'd1);
    issue(0, 1, "wrap_b161");
    issue(159, 0, "wrap_b160");
    issue(1, 1, "wrap_fill");
    flush();

    // Backspace, including at column 0
    send(CC_BS, 8'h00);
    check("bs_col", 32'(o_cur_col), 32'd0);
    send(CC_BS, 8'h00);
    check("bs0_col", 32'(o_cur_col), 32'd0);
    check("bs0_row", 32'(o_cur_row), 32'd1);
    rd(0, 1, "bs_nowrite");

    // Move to the bottom row and scroll with LF
    for (int i = 0; i < 88; i++) send(CC_LF, 8'h00);
    check("lf_row", 32'(o_cur_row), 32'd89);
    send(8'h5A, 8'h4B);
    send(CC_LF, 8'h00);
    count_busy(160, "scroll_busy");
    check("scroll_row", 32'(o_cur_row), 32'd89);
    check("scroll_col", 32'(o_cur_col), 32'd0);
    issue(0, 0, "scr_r0");
    issue(159, 0, "scr_r0_end");
    issue(0, 88, "scr_r88");
    issue(5, 89, "scr_fill");
    flush();

    // Wrap on the last cell of the last row scrolls like LF
    for (int i = 0; i < 159; i++) send(8'h6D, 8'h5A);
    check("lastcol_col", 32'(o_cur_col), 32'd159);
    send(8'h71, 8'h69);
    count_busy(160, "wrap_busy");
    check("wscr_col", 32'(o_cur_col), 32'd0);
    check("wscr_row", 32'(o_cur_row), 32'd89);
    issue(159, 88, "wscr_q");
    issue(0, 89, "wscr_fill");
    issue(10, 0, "wscr_r0");
    flush();

    // Out-of-range coordinates, streamed back to back
    issue(160, 0, "oor_col");
    issue(0, 90, "oor_row");
    issue(511, 511, "oor_max");
    issue(3, 3, "oor_after");
    flush();

    // Same-cycle write and read of one address returns the old value
    old_cell = scr[89][0];
    bus.valid = 1'b1; bus.data = 8'h55; bus.attr = 8'h3C;
    i_bx = 9'd0; i_by = 9'd89;
    @(negedge i_pclk);
    bus.valid = 1'b0;
    check("rw_same_old", 32'(o_char), 32'(old_cell));
    m_byte(8'h55, 8'h3C);
    rd(0, 89, "rw_same_new");

    // Form feed mid-screen: full clear with the current attribute
    send(8'h78, 8'h2E);
    send(CC_FF, 8'h00);
    count_busy(14400, "ff_busy");
    check("ff_col", 32'(o_cur_col), 32'd0);
    check("ff_row", 32'(o_cur_row), 32'd0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        issue(c, r, "ff_cell");
    flush();

    // Reset 5000 cycles into a clear restarts the full clear
    send(8'h6B, 8'h2E);
    send(CC_FF, 8'h00);
    repeat (5000) @(negedge i_pclk);
    i_rst = 1'b1;
    @(negedge i_pclk);
    i_rst = 1'b0;
    m_reset();
    count_busy(14400, "rst2_busy");
    check("rst2_col", 32'(o_cur_col), 32'd0);
    check("rst2_row", 32'(o_cur_row), 32'd0);
    issue(100, 80, "rst2_far");
    issue(0, 0, "rst2_origin");
    issue(159, 89, "rst2_last");
    flush();
    send(8'h42, 8'h1F);
    rd(0, 0, "rst2_B");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
